nth_root: RTL and testbench

- Calculator execution unit computing the integer n-th root, y = floor(a^(1/b)), the inverse of the exponentiation unit.
- Sits beside the other ALU operators and is enabled by the global controller state and opcode.
- Result is returned in Q16.8 format (integer root << 8), so it lines up with power-unit results.
- Root is found bit-serially: trial bits MSB-first, trial^b by repeated multiplication with early abort.

---
 rtl/nth_root.sv | 142 ++++++++++++++
 tb/tb_nth_root.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nth_root.sv
// Integer n-th root unit: o_root = floor(a^(1/b)) in Q16.8, found bit-serially
// MSB-first with trial^b built by repeated multiplication and early abort.
module nth_root #(
    parameter int         N     = 16,
    parameter int         M     = 32,
    parameter logic [2:0] EXECB = 3'd3,
    parameter logic [3:0] ROOT  = 4'd7
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic [2:0]          state,
    input  logic [3:0]          opcode,
    output logic signed [M-1:0] o_root,
    output logic                error,
    output logic                done
);
    localparam int K  = (N + 1) / 2;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = 2 * N;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_TRIAL, S_MULT, S_CMP, S_DONE
    } st_t;

    st_t                st_q, st_d;
    logic signed [N-1:0] a_q, a_d, b_q, b_d;
    logic [K-1:0]       y_q, y_d, trial_q, trial_d;
    logic [KW-1:0]      k_q, k_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [N-1:0]       cnt_q, cnt_d;
    logic [M-1:0]       root_q, root_d;
    logic               err_q, err_d;

    logic               i_ce;
    logic [PW-1:0]      a_ext;
    logic [K-1:0]       t_new, y_nxt;

    assign i_ce  = (state == EXECB) && (opcode == ROOT);
    // Radicand is known non-negative once the iterative path is entered.
    assign a_ext = PW'($unsigned(a_q));

    always_comb begin
        st_d    = st_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        k_d     = k_q;
        trial_d = trial_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        err_d   = err_q;
        t_new   = y_q | (K'(1) << k_q);
        y_nxt   = (prod_q <= a_ext) ? trial_q : y_q;
        case (st_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (i_ce) begin
                    a_d  = a;
                    b_d  = b;
                    st_d = S_CHECK;
                end
            end
            S_CHECK: begin
                st_d = S_DONE;
                if (b_q <= 0 || a_q < 0) begin
                    err_d  = 1'b1;
                    root_d = M'(32'hDEADBEEF);
                end else if (a_q == 0) begin
                    root_d = '0;
                end else if (b_q == 1) begin
                    root_d = M'({a_q, 8'b0});
                end else if (b_q >= N - 1) begin
                    // Radicand < 2^(N-1), so any degree this large yields 1.
                    root_d = M'(9'h100);
                end else begin
                    y_d  = '0;
                    k_d  = KW'(K - 1);
                    st_d = S_TRIAL;
                end
            end
            S_TRIAL: begin
                trial_d = t_new;
                prod_d  = PW'(t_new);
                cnt_d   = $unsigned(b_q) - N'(1);
                st_d    = S_MULT;
            end
            S_MULT: begin
                if (cnt_q == '0 || prod_q > a_ext) begin
                    st_d = S_CMP;
                end else begin
                    prod_d = prod_q * PW'(trial_q);
                    cnt_d  = cnt_q - N'(1);
                end
            end
            S_CMP: begin
                y_d = y_nxt;
                if (k_q == '0) begin
                    root_d = M'({y_nxt, 8'b0});
                    st_d   = S_DONE;
                end else begin
                    k_d  = k_q - KW'(1);
                    st_d = S_TRIAL;
                end
            end
            S_DONE:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q    <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            trial_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            k_q     <= k_d;
            trial_q <= trial_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            err_q   <= err_d;
        end
    end

    assign o_root = root_q;
    assign done   = (st_q == S_DONE);
    assign error  = (st_q == S_DONE) && err_q;
endmodule

// File: tb/tb_nth_root.sv
// Self-checking bench for nth_root: directed plan cases plus randomized operands
// checked against a plain-arithmetic floor-root model.
module tb_nth_root;
    localparam logic [2:0] EXECB = 3'd3;
    localparam logic [3:0] ROOT  = 4'd7;

    logic               CLK = 1'b0;
    logic               RST;
    logic signed [15:0] a, b;
    logic [2:0]         state;
    logic [3:0]         opcode;
    logic signed [31:0] o_root;
    logic               error, done;

    int total = 0;
    int bad   = 0;

    nth_root #(.N(16), .M(32), .EXECB(EXECB), .ROOT(ROOT)) dut (
        .CLK(CLK), .RST(RST), .a(a), .b(b), .state(state), .opcode(opcode),
        .o_root(o_root), .error(error), .done(done)
    );

    always #5 CLK = ~CLK;

    // True when x^e <= lim, stopping as soon as the partial power exceeds lim.
    function automatic bit pow_le(input longint x, input int e, input longint lim);
        longint p = 1;
        for (int i = 0; i < e; i++) begin
            p = p * x;
            if (p > lim) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void ref_root(input int av, input int bv,
                                     output logic [31:0] r, output logic e);
        longint y = 0;
        if (bv <= 0 || av < 0) begin
            r = 32'hDEADBEEF;
            e = 1'b1;
        end else begin
            while (pow_le(y + 1, bv, longint'(av))) y++;
            r = 32'(y * 256);
            e = 1'b0;
        end
    endfunction

    // Issues one operation with i_ce for a single cycle; lat counts the i_ce cycle as 1.
    task automatic run_op(input int av, input int bv, output logic [31:0] res,
                          output logic err, output int lat, output bit to,
                          output bit pulse_ok);
        @(negedge CLK);
        a = av[15:0]; b = bv[15:0]; state = EXECB; opcode = ROOT;
        @(posedge CLK);
        lat = 1;
        to  = 1'b1;
        res = '0;
        err = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            state = 3'd0;
            lat++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        if (!to) begin
            res = o_root;
            err = error;
        end
        @(negedge CLK);
        pulse_ok = !done && !error;
    endtask

    task automatic test_reset();
        RST = 1'b1; a = '0; b = '0; state = 3'd0; opcode = 4'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++; if (o_root !== 32'h0) begin bad++; $display("FAIL reset_root: got %h want %h", o_root, 32'h0); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        RST = 1'b0;
    endtask

    task automatic test_directed();
        int          da[10] = '{27, 100, 99, 32767, 1234, 0, 5000, -8, 16, 16};
        int          db[10] = '{3, 2, 2, 2, 1, 5, 15, 3, 0, -2};
        logic [31:0] de[10] = '{32'h300, 32'hA00, 32'h900, 32'hB500, 32'h4D200, 32'h0,
                                32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        logic [31:0] res;
        logic        err, exp_err;
        int          lat;
        bit          to, pulse_ok;
        for (int i = 0; i < 10; i++) begin
            run_op(da[i], db[i], res, err, lat, to, pulse_ok);
            exp_err = (i >= 7);
            total++; if (to) begin bad++; $display("FAIL dir_timeout[%0d]: no done within bound", i); end
            total++; if (res !== de[i]) begin bad++; $display("FAIL dir_root[%0d] a=%0d b=%0d: got %h want %h", i, da[i], db[i], res, de[i]); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL dir_error[%0d]: got %b want %b", i, err, exp_err); end
            total++; if (!pulse_ok) begin bad++; $display("FAIL dir_pulse[%0d]: done/error not a single-cycle pulse", i); end
            if (i >= 4) begin
                total++; if (lat != 3) begin bad++; $display("FAIL dir_latency[%0d]: got %0d want 3", i, lat); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, exp_r;
        logic        err, exp_e;
        int          av, bv, lat;
        bit          to, pulse_ok, fast;
        for (int i = 0; i < 60; i++) begin
            av = ($urandom_range(0, 7) == 0) ? -int'($urandom_range(1, 32768))
                                             : int'($urandom_range(0, 32767));
            bv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6))
                                             : int'($urandom_range(0, 19)) - 2;
            ref_root(av, bv, exp_r, exp_e);
            fast = (bv <= 0) || (av <= 0) || (bv == 1) || (bv >= 15);
            run_op(av, bv, res, err, lat, to, pulse_ok);
            total++; if (to) begin bad++; $display("FAIL rnd_timeout a=%0d b=%0d", av, bv); end
            total++; if (res !== exp_r || err !== exp_e) begin
                bad++; $display("FAIL rnd_root a=%0d b=%0d: got %h/%b want %h/%b", av, bv, res, err, exp_r, exp_e);
            end
            total++; if (!pulse_ok) begin bad++; $display("FAIL rnd_pulse a=%0d b=%0d", av, bv); end
            if (fast) begin
                total++; if (lat != 3) begin bad++; $display("FAIL rnd_latency a=%0d b=%0d: got %0d want 3", av, bv, lat); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        err;
        int          lat, dones;
        bit          to, pulse_ok;
        @(negedge CLK);
        a = 16'sd32767; b = 16'sd3; state = EXECB; opcode = ROOT;
        @(posedge CLK);
        @(negedge CLK);
        state = 3'd0;
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        total++; if (o_root !== 32'h0) begin bad++; $display("FAIL midrst_root: got %h want %h", o_root, 32'h0); end
        RST = 1'b0;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midrst_nodone: got %0d dones want 0", dones); end
        run_op(64, 3, res, err, lat, to, pulse_ok);
        total++; if (to || res !== 32'h400 || err !== 1'b0) begin
            bad++; $display("FAIL midrst_fresh: got %h/%b want %h/0", res, err, 32'h400);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        @(negedge CLK);
        a = 16'sd200; b = 16'sd2; state = EXECB; opcode = ROOT;
        for (int i = 0; i < 600 && n < 2; i++) begin
            @(negedge CLK);
            if (done) begin
                n++;
                total++; if (o_root !== 32'hE00) begin bad++; $display("FAIL b2b_root[%0d]: got %h want %h", n, o_root, 32'hE00); end
            end
        end
        state = 3'd0;
        total++; if (n != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", n); end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_inflight();
        bit got = 1'b0;
        @(negedge CLK);
        a = 16'sd200; b = 16'sd2; state = EXECB; opcode = ROOT;
        @(posedge CLK);
        #1;
        a = 16'sd5; b = 16'sd7; state = 3'd0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (done) got = 1'b1;
        end
        total++; if (!got || o_root !== 32'hE00) begin
            bad++; $display("FAIL inflight_root: got %h done=%b want %h", o_root, got, 32'hE00);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
